// File: rtl/phy_rx_demux.sv
// Receive-side lane demultiplexer: rebuilds 4-word groups from the serialized
// clk_4f stream and presents each complete group with a one-cycle strobe.
module phy_rx_demux #(
    parameter int WIDTH     = 9,
    parameter int ALIGN_DLY = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data0,
    output logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] data3,
    output logic             out_valid,
    output logic             locked,
    output logic [CNT_W-1:0] group_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    // WAIT leaves one cycle early so that the RUN edge at cycle ALIGN_DLY captures lane 0.
    localparam logic [3:0] DLY_LAST = 4'((ALIGN_DLY > 1) ? (ALIGN_DLY - 1) : 0);

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [3:0]       dly_q, dly_d;
    logic [WIDTH-1:0] hold_q [3];
    logic [WIDTH-1:0] hold_d [3];
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic             out_valid_q, out_valid_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        dly_d       = dly_q;
        hold_d      = hold_q;
        data_d      = data_q;
        out_valid_d = 1'b0;
        cnt_d       = cnt_q;
        capture     = 1'b0;

        case (state_q)
            IDLE: begin
                phase_d = 2'd0;
                dly_d   = 4'd0;
                if (ALIGN_DLY == 0) begin
                    // No transmit latency: the cycle-0 word is already lane 0.
                    state_d = RUN;
                    capture = 1'b1;
                end else if (ALIGN_DLY == 1) begin
                    state_d = RUN;
                end else begin
                    state_d = WAIT;
                    dly_d   = 4'd1;
                end
            end
            WAIT: begin
                if (dly_q == DLY_LAST) begin
                    state_d = RUN;
                    phase_d = 2'd0;
                end else begin
                    dly_d = dly_q + 4'd1;
                end
            end
            RUN: begin
                capture = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
                data_d[0]   = hold_q[0];
                data_d[1]   = hold_q[1];
                data_d[2]   = hold_q[2];
                data_d[3]   = data_in;
                out_valid_d = 1'b1;
                cnt_d       = cnt_q + CNT_W'(1);
            end else begin
                hold_d[phase_q] = data_in;
            end
        end

        locked_d = (state_d == RUN);
    end

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            state_q     <= IDLE;
            phase_q     <= 2'd0;
            dly_q       <= 4'd0;
            out_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            dly_q       <= dly_d;
            out_valid_q <= out_valid_d;
            locked_q    <= locked_d;
            cnt_q       <= cnt_d;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_hold
        always_ff @(posedge clk_4f) begin
            if (!reset) begin
                hold_q[gi] <= '0;
            end else begin
                hold_q[gi] <= hold_d[gi];
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_data
        always_ff @(posedge clk_4f) begin
            if (!reset) begin
                data_q[gi] <= '0;
            end else begin
                data_q[gi] <= data_d[gi];
            end
        end
    end

    assign data0       = data_q[0];
    assign data1       = data_q[1];
    assign data2       = data_q[2];
    assign data3       = data_q[3];
    assign out_valid   = out_valid_q;
    assign locked      = locked_q;
    assign group_count = cnt_q;

endmodule

// File: tb/tb_phy_rx_demux.sv
// Bench for phy_rx_demux: vector table for reset and first group, then a
// cycle-accurate scoreboard over streaming, reset and ALIGN_DLY=0 corner cases.
module tb_phy_rx_demux;

    localparam int ALIGN = 2;

    logic       clk;
    logic       reset;
    logic [8:0] data_in;
    logic [8:0] data0, data1, data2, data3;
    logic       out_valid, locked;
    logic [7:0] group_count;

    logic       reset0;
    logic [8:0] din0;
    logic [8:0] z_data0, z_data1, z_data2, z_data3;
    logic       z_valid, z_locked;
    logic [7:0] z_count;

    int checks   = 0;
    int failures = 0;

    phy_rx_demux #(.WIDTH(9), .ALIGN_DLY(ALIGN), .CNT_W(8)) u_dut (
        .clk_4f(clk), .reset(reset), .data_in(data_in),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .out_valid(out_valid), .locked(locked), .group_count(group_count)
    );

    phy_rx_demux #(.WIDTH(9), .ALIGN_DLY(0), .CNT_W(8)) u_dut0 (
        .clk_4f(clk), .reset(reset0), .data_in(din0),
        .data0(z_data0), .data1(z_data1), .data2(z_data2), .data3(z_data3),
        .out_valid(z_valid), .locked(z_locked), .group_count(z_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       rst;
        logic [8:0] din;
        logic       v;
        logic       lk;
        logic [8:0] d0, d1, d2, d3;
        logic [7:0] cnt;
    } vec_t;

    typedef struct packed {
        logic [3:0][8:0] d;
        logic [7:0]      cnt;
    } grp_t;

    // Reference model state
    int              cyc;
    logic [3:0][8:0] lanes;
    logic [3:0][8:0] last;
    logic [7:0]      exp_cnt;
    grp_t            sbq[$];
    int              nstrobes;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one word for one clk_4f cycle, update the model, check after the edge.
    task automatic step(input logic rst, input logic [8:0] w);
        grp_t g;
        int   p;
        reset   = rst;
        data_in = w;
        if (!rst) begin
            cyc     = -1;
            exp_cnt = 8'd0;
            last    = '0;
            sbq.delete();
        end else begin
            cyc++;
            if (cyc >= ALIGN) begin
                p        = (cyc - ALIGN) % 4;
                lanes[p] = w;
                if (p == 3) begin
                    exp_cnt = exp_cnt + 8'd1;
                    g.d     = lanes;
                    g.cnt   = exp_cnt;
                    sbq.push_back(g);
                end
            end
        end
        @(negedge clk);
        chk("locked", locked, (rst && (cyc >= ALIGN - 1)) ? 32'd1 : 32'd0);
        if (sbq.size() > 0) begin
            g = sbq.pop_front();
            chk("out_valid_hi", out_valid, 1);
            last = g.d;
        end else begin
            chk("out_valid_lo", out_valid, 0);
        end
        if (out_valid === 1'b1) nstrobes++;
        chk("data0", data0, last[0]);
        chk("data1", data1, last[1]);
        chk("data2", data2, last[2]);
        chk("data3", data3, last[3]);
        chk("group_count", group_count, exp_cnt);
    endtask

    vec_t vecs[12];

    initial begin
        bit seen;
        int when;

        reset    = 1'b0;
        data_in  = 9'h000;
        reset0   = 1'b0;
        din0     = 9'h000;
        cyc      = -1;
        lanes    = '0;
        last     = '0;
        exp_cnt  = 8'd0;
        nstrobes = 0;

        // {rst, din, valid, locked, d0, d1, d2, d3, count}
        for (int i = 0; i < 5; i++)
            vecs[i] = '{1'b0, 9'h1FF, 1'b0, 1'b0, 9'h0, 9'h0, 9'h0, 9'h0, 8'd0};
        vecs[5]  = '{1'b1, 9'h1AA, 1'b0, 1'b0, 9'h0, 9'h0, 9'h0, 9'h0, 8'd0};
        vecs[6]  = '{1'b1, 9'h1BB, 1'b0, 1'b1, 9'h0, 9'h0, 9'h0, 9'h0, 8'd0};
        vecs[7]  = '{1'b1, 9'h101, 1'b0, 1'b1, 9'h0, 9'h0, 9'h0, 9'h0, 8'd0};
        vecs[8]  = '{1'b1, 9'h102, 1'b0, 1'b1, 9'h0, 9'h0, 9'h0, 9'h0, 8'd0};
        vecs[9]  = '{1'b1, 9'h103, 1'b0, 1'b1, 9'h0, 9'h0, 9'h0, 9'h0, 8'd0};
        vecs[10] = '{1'b1, 9'h104, 1'b1, 1'b1, 9'h101, 9'h102, 9'h103, 9'h104, 8'd1};
        vecs[11] = '{1'b1, 9'h000, 1'b0, 1'b1, 9'h101, 9'h102, 9'h103, 9'h104, 8'd1};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].din);
            chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].v);
            chk($sformatf("vec%0d_locked", i), locked, vecs[i].lk);
            chk($sformatf("vec%0d_d0", i), data0, vecs[i].d0);
            chk($sformatf("vec%0d_d1", i), data1, vecs[i].d1);
            chk($sformatf("vec%0d_d2", i), data2, vecs[i].d2);
            chk($sformatf("vec%0d_d3", i), data3, vecs[i].d3);
            chk($sformatf("vec%0d_cnt", i), group_count, vecs[i].cnt);
        end

        // 300-group continuous stream
        step(1'b0, 9'h000);
        step(1'b0, 9'h000);
        for (int i = 0; i < ALIGN; i++) step(1'b1, 9'h0EE);
        nstrobes = 0;
        for (int n = 0; n < 300; n++)
            for (int p = 0; p < 4; p++)
                step(1'b1, {1'b1, 8'(4 * n + p)});
        chk("stream_strobes", nstrobes, 300);
        chk("stream_count_wrap", group_count, 44);

        // Zero word on lane 2
        step(1'b1, 9'h101);
        step(1'b1, 9'h102);
        step(1'b1, 9'h000);
        step(1'b1, 9'h104);
        chk("zero_lane_valid", out_valid, 1);
        chk("zero_lane_d2", data2, 9'h000);
        chk("zero_lane_d1", data1, 9'h102);
        chk("zero_lane_d3", data3, 9'h104);

        // Reset pulse after lanes 0 and 1 of a group
        step(1'b1, 9'h1C1);
        step(1'b1, 9'h1C2);
        step(1'b0, 9'h1C3);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_d0", data0, 0);
        seen = 1'b0;
        when = -1;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1'b1, 9'h1D0 + 9'(k));
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                when = k;
            end
        end
        chk("midrst_strobe_seen", seen, 1);
        chk("midrst_strobe_cycle", when, ALIGN + 3);
        chk("midrst_fresh_d0", data0, 9'h1D0 + 9'(ALIGN));

        // Reset coinciding with phase 3
        step(1'b1, 9'h111);
        step(1'b1, 9'h112);
        step(1'b1, 9'h113);
        step(1'b0, 9'h114);
        chk("rst_ph3_valid", out_valid, 0);
        chk("rst_ph3_d3", data3, 0);
        chk("rst_ph3_cnt", group_count, 0);

        // ALIGN_DLY=0 instance: cycle-0 word is lane 0, first strobe at cycle 4
        reset = 1'b0;
        @(negedge clk);
        chk("a0_reset_valid", z_valid, 0);
        chk("a0_reset_locked", z_locked, 0);
        reset0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            din0 = 9'h1A0 + 9'(k);
            @(negedge clk);
            chk($sformatf("a0_valid_c%0d", k), z_valid, (k == 3) ? 32'd1 : 32'd0);
            chk($sformatf("a0_locked_c%0d", k), z_locked, 1);
            if (k == 3) begin
                chk("a0_d0", z_data0, 9'h1A0);
                chk("a0_d1", z_data1, 9'h1A1);
                chk("a0_d2", z_data2, 9'h1A2);
                chk("a0_d3", z_data3, 9'h1A3);
                chk("a0_cnt", z_count, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phy_rx_demux.md
Name: phy_rx_demux

Overview:
Receive-side counterpart of the 4-lane PHY transmit mux. It takes the single 9-bit serialized stream produced at clk_4f and distributes the words round-robin back onto four parallel 9-bit lanes. It presents each complete 4-word group at once, qualified by a one-cycle strobe. It sits at the receive end of the PHY link, feeding the lane-side logic. The whole block runs in the clk_4f domain with one clock only.

Parameters:
WIDTH, 9, lane word width; bit WIDTH-1 is the word-valid flag, bits WIDTH-2:0 are data.
ALIGN_DLY, 2, number of clk_4f cycles between reset release and the first lane-0 word on data_in. This is the transmit pipeline latency; legal range is 0..15.
CNT_W, 8, width of group_count.

Ports:
clk_4f  in  1  sole clock; all logic on its rising edge.
reset  in  1  synchronous, active-low reset, sampled on the clk_4f rising edge.
data_in  in  WIDTH  serialized stream from the transmit mux; one word per clk_4f cycle.
data0  out  WIDTH  lane-0 word of the last completed group.
data1  out  WIDTH  lane-1 word of the last completed group.
data2  out  WIDTH  lane-2 word of the last completed group.
data3  out  WIDTH  lane-3 word of the last completed group.
out_valid  out  1  one-cycle strobe; high in the cycle in which data0..data3 first show a new group.
locked  out  1  high while the FSM is in RUN.
group_count  out  CNT_W  number of groups delivered since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset==0 at a rising edge):
  - FSM goes to IDLE.
  - data0..data3, out_valid, locked, group_count, the phase counter, the delay counter and the lane holding registers all go to 0.
  - Reset has priority over every other event.
- Cycle numbering: the first rising edge with reset==1 is cycle 0.
  - The word sampled at cycle ALIGN_DLY + 4n + p belongs to lane p, for p = 0..3.
- FSM states:
  - IDLE: held while reset==0. At the first edge with reset==1, go to WAIT if ALIGN_DLY > 0; otherwise go directly to RUN and treat the cycle-0 word as lane 0 (phase 0 is captured in that same edge).
  - WAIT: the delay counter increments each cycle and data_in is ignored. After ALIGN_DLY cycles (cycles 0..ALIGN_DLY-1), go to RUN with phase = 0.
  - RUN: locked==1. The 2-bit phase counter increments each cycle and wraps 3 to 0.
- Capture in RUN:
  - Phase 0..2: hold[phase] <= data_in.
  - Phase 3: data0 <= hold0, data1 <= hold1, data2 <= hold2, data3 <= data_in; out_valid <= 1; group_count <= group_count + 1 (255 wraps to 0).
  - Every other cycle: out_valid <= 0.
  - data0..data3 hold their values between strobes.
- Latency: the lane-3 word sampled at edge k appears on data3 with out_valid==1 after edge k. For ALIGN_DLY=2, the first strobe is at cycle 6 (the output registers update at the cycle-5 edge).
- Words are passed through unmodified, including words with valid bit 0. No filtering is done; the consumer qualifies each lane using bit WIDTH-1.
- Reset mid-group: the partial group is discarded, no strobe is issued, and alignment restarts from cycle 0 after release.
- Reset asserted in the same cycle as phase 3: reset wins; out_valid stays 0 and outputs clear.
- The phase counter never skips or stalls in RUN. Realignment happens only through reset.

Test Plan:
- Reset held 5 cycles with data_in=9'h1FF → all outputs 0, locked=0 throughout; out_valid never asserts.
- ALIGN_DLY=2, release reset, then drive 9'h1AA,9'h1BB (ignored), 9'h101,9'h102,9'h103,9'h104 → at cycle 6: data0..3 = 101/102/103/104, out_valid=1 for exactly one cycle, group_count=1, locked=1 from cycle 2.
- Continuous stream of 300 groups with lane p carrying {1'b1, 8'(4n+p)} → every group is reconstructed in order, out_valid has 4-cycle periodicity, and group_count wraps 255→0 then reaches 44.
- Group containing 9'h000 in lane 2 → data2 = 9'h000 with out_valid=1; the other lanes are unaffected.
- Reset pulsed low for 1 cycle after lanes 0 and 1 of a group are sampled → no strobe for that group, outputs cleared, and the next strobe arrives 4+ALIGN_DLY cycles after release with fresh data.
- ALIGN_DLY=0: the word at cycle 0 lands on data0 and the first strobe occurs at cycle 4.
